uart_block_tx: RTL



---
 rtl/uart_block_tx_if.sv | 25 ++
 rtl/uart_block_tx.sv | 83 ++++++++
 2 files changed

// File: rtl/uart_block_tx_if.sv
// uart_block_tx_if: block handshake, TX FIFO write port and status of the block serializer.
interface uart_block_tx_if #(
    parameter int NUM_BYTES = 64,
    parameter int CNT_W = 7
);
    logic [NUM_BYTES*8-1:0] blk_data;
    logic blk_valid;
    logic blk_ready;
    logic tx_full;
    logic tx_wr;
    logic [7:0] tx_wr_data;
    logic busy;
    logic done;
    logic [CNT_W-1:0] byte_cnt;

    modport slave (
        input blk_data, blk_valid, tx_full,
        output blk_ready, tx_wr, tx_wr_data, busy, done, byte_cnt
    );

    modport master (
        output blk_data, blk_valid, tx_full,
        input blk_ready, tx_wr, tx_wr_data, busy, done, byte_cnt
    );
endinterface

// File: rtl/uart_block_tx.sv
// uart_block_tx: writes a NUM_BYTES block into the UART TX FIFO, one byte per non-full cycle, then pulses done.
// Define UART_BLOCK_TX_CRLF_EN to append 0x0D 0x0A after every block.
module uart_block_tx #(
    parameter int NUM_BYTES = 64,
    parameter int CNT_W = 7
) (
    input logic clk_100MHz,
    input logic reset,
    uart_block_tx_if.slave bus
);
`ifdef UART_BLOCK_TX_CRLF_EN
    typedef enum logic [1:0] {IDLE, SEND, TERM, DONE} state_t;
    localparam logic [CNT_W-1:0] CR_IDX = CNT_W'(NUM_BYTES);
    localparam logic [CNT_W-1:0] LF_IDX = CNT_W'(NUM_BYTES + 1);
`else
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    state_t r_state, w_next;
    logic [NUM_BYTES*8-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic w_accept, w_wr;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_shift <= bus.blk_data;
                r_cnt <= '0;
            end else if (w_wr) begin
                r_shift <= r_shift << 8;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_accept = 1'b0;
        w_wr = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = bus.blk_valid;
                w_next = bus.blk_valid ? SEND : IDLE;
            end
`ifdef UART_BLOCK_TX_CRLF_EN
            SEND: begin
                w_wr = !bus.tx_full;
                w_next = (w_wr && r_cnt == LAST_IDX) ? TERM : SEND;
            end
            TERM: begin
                w_wr = !bus.tx_full;
                w_next = (w_wr && r_cnt == LF_IDX) ? DONE : TERM;
            end
`else
            SEND: begin
                w_wr = !bus.tx_full;
                w_next = (w_wr && r_cnt == LAST_IDX) ? DONE : SEND;
            end
`endif
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The shift register is emptied by the time TERM runs, so the terminator bytes are muxed in from the count.
`ifdef UART_BLOCK_TX_CRLF_EN
    assign bus.tx_wr_data = (r_state == TERM) ? ((r_cnt == CR_IDX) ? 8'h0D : 8'h0A)
                                              : r_shift[NUM_BYTES*8-1 -: 8];
`else
    assign bus.tx_wr_data = r_shift[NUM_BYTES*8-1 -: 8];
`endif
    assign bus.tx_wr = w_wr;
    assign bus.blk_ready = (r_state == IDLE);
    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
    assign bus.byte_cnt = r_cnt;
endmodule
